// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the DVP camera capture block.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    CAPTURE   = 2'd2,
    LINE_END  = 2'd3
  } cap_state_e;

  localparam logic       FIFO_SEL_1 = 1'b0;
  localparam logic       FIFO_SEL_2 = 1'b1;
  localparam logic [7:0] PAD_BYTE   = 8'h00;
  localparam int         LINE_CNT_W = 12;
  localparam int         BYTE_W     = 8;

  // Line counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LINE_CNT_W-1:0] sat_inc(input logic [LINE_CNT_W-1:0] v);
    logic [LINE_CNT_W-1:0] r;
    r = (&v) ? v : v + LINE_CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO used as one line store.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
// The write pointer is published to the read side one cycle after the
// write, so a freshly written word becomes visible two clocks after the
// producer registered it.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      wr_vis_q, wr_vis_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_vis_q == rd_ptr_q);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  // Accept pops only when data is visible; a full FIFO still accepts a push
  // when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    wr_vis_d = wr_ptr_q;
  end

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vis_q <= wr_vis_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dvp_pingpong_line_buffer.sv
// DVP camera capture: packs byte pairs into 16-bit pixels and ping-pongs
// whole lines between two FWFT FIFOs (even lines FIFO1, odd lines FIFO2).
// Optional build macro DVP_TEST_PATTERN_EN adds i_test_mode, which replaces
// captured pixels with {line_cnt[3:0], column[11:0]}.
module dvp_pingpong_line_buffer
  import cam_capture_pkg::*;
#(
  parameter int   FIFO_DEPTH   = 1024,
  parameter int   PIX_WIDTH    = 16,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pix_en,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [BYTE_W-1:0]     i_data,
`ifdef DVP_TEST_PATTERN_EN
  input  logic                  i_test_mode,
`endif
  input  logic                  i_fifo_rd_en,
  input  logic                  i_fifo_choose,
  output logic [PIX_WIDTH-1:0]  o_fifo1_rd_data,
  output logic [PIX_WIDTH-1:0]  o_fifo2_rd_data,
  output logic                  o_fifo1_empty,
  output logic                  o_fifo2_empty,
  output logic                  o_line_done,
  output logic                  o_frame_start,
  output logic                  o_overflow,
  output logic [LINE_CNT_W-1:0] o_line_cnt
);

  cap_state_e            state_q, state_d;
  logic                  parity_q, parity_d;
  logic                  phase_q, phase_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [PIX_WIDTH-1:0]  pix_q, pix_d;
  logic                  push_q, push_d;
  logic                  push_sel_q, push_sel_d;
  logic                  line_done_q, line_done_d;
  logic                  frame_start_q, frame_start_d;
  logic                  overflow_q, overflow_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
`ifdef DVP_TEST_PATTERN_EN
  logic [11:0]           col_cnt_q, col_cnt_d;
`endif

  logic                  vsync_act;
  logic                  take_byte;
  logic [PIX_WIDTH-1:0]  pair_pix;
  logic [PIX_WIDTH-1:0]  pad_pix;
  logic                  push1, push2;
  logic                  pop1, pop2;
  logic                  full1, full2;
  logic                  empty1, empty2;
  logic                  drop;

  assign vsync_act = (i_vsync == VSYNC_ACTIVE);

  assign push1 = push_q && (push_sel_q == FIFO_SEL_1);
  assign push2 = push_q && (push_sel_q == FIFO_SEL_2);
  assign pop1  = i_fifo_rd_en && (i_fifo_choose == FIFO_SEL_1);
  assign pop2  = i_fifo_rd_en && (i_fifo_choose == FIFO_SEL_2);

  // Pixel candidates for a completed pair and for a padded odd trailing byte.
  always_comb begin
    pair_pix = {byte_q, i_data};
    pad_pix  = {byte_q, PAD_BYTE};
`ifdef DVP_TEST_PATTERN_EN
    if (i_test_mode) begin
      pair_pix = {line_cnt_q[3:0], col_cnt_q};
      pad_pix  = {line_cnt_q[3:0], col_cnt_q};
    end
`endif
  end

  // A push into a full FIFO is lost unless the same FIFO pops this cycle.
  always_comb begin
    drop = (push1 && full1 && !(pop1 && !empty1)) ||
           (push2 && full2 && !(pop2 && !empty2));
  end

  // Capture FSM next state, byte packing and line/frame bookkeeping.
  always_comb begin
    state_d       = state_q;
    parity_d      = parity_q;
    phase_d       = phase_q;
    byte_d        = byte_q;
    pix_d         = pix_q;
    push_d        = 1'b0;
    push_sel_d    = push_sel_q;
    line_done_d   = 1'b0;
    frame_start_d = 1'b0;
    overflow_d    = overflow_q | drop;
    line_cnt_d    = line_cnt_q;
    take_byte     = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
    col_cnt_d     = col_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_pix_en && !vsync_act) begin
          state_d       = WAIT_LINE;
          frame_start_d = 1'b1;
          parity_d      = FIFO_SEL_1;
          line_cnt_d    = '0;
          overflow_d    = 1'b0;
          phase_d       = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
          col_cnt_d     = '0;
`endif
        end
      end
      WAIT_LINE: begin
        if (i_pix_en) begin
          if (vsync_act) begin
            state_d = IDLE;
            phase_d = 1'b0;
          end else if (i_href) begin
            state_d   = CAPTURE;
            take_byte = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (i_pix_en) begin
          if (vsync_act) begin
            state_d = IDLE;
            phase_d = 1'b0;
          end else if (i_href) begin
            take_byte = 1'b1;
          end else begin
            state_d = LINE_END;
          end
        end
      end
      LINE_END: begin
        if (i_pix_en && vsync_act) begin
          state_d = IDLE;
          phase_d = 1'b0;
        end else begin
          state_d = WAIT_LINE;
          if (phase_q) begin
            pix_d      = pad_pix;
            push_d     = 1'b1;
            push_sel_d = parity_q;
          end
          line_done_d = 1'b1;
          parity_d    = ~parity_q;
          line_cnt_d  = sat_inc(line_cnt_q);
          phase_d     = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
          col_cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_byte) begin
      if (!phase_q) begin
        byte_d  = i_data;
        phase_d = 1'b1;
      end else begin
        pix_d      = pair_pix;
        push_d     = 1'b1;
        push_sel_d = parity_q;
        phase_d    = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
        col_cnt_d  = col_cnt_q + 12'd1;
`endif
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      parity_q      <= FIFO_SEL_1;
      phase_q       <= 1'b0;
      byte_q        <= '0;
      pix_q         <= '0;
      push_q        <= 1'b0;
      push_sel_q    <= FIFO_SEL_1;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
      line_cnt_q    <= '0;
`ifdef DVP_TEST_PATTERN_EN
      col_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      parity_q      <= parity_d;
      phase_q       <= phase_d;
      byte_q        <= byte_d;
      pix_q         <= pix_d;
      push_q        <= push_d;
      push_sel_q    <= push_sel_d;
      line_done_q   <= line_done_d;
      frame_start_q <= frame_start_d;
      overflow_q    <= overflow_d;
      line_cnt_q    <= line_cnt_d;
`ifdef DVP_TEST_PATTERN_EN
      col_cnt_q     <= col_cnt_d;
`endif
    end
  end

  sync_fifo_fwft #(
    .WIDTH(PIX_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push1),
    .din  (pix_q),
    .pop  (pop1),
    .dout (o_fifo1_rd_data),
    .full (full1),
    .empty(empty1)
  );

  sync_fifo_fwft #(
    .WIDTH(PIX_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo2 (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push2),
    .din  (pix_q),
    .pop  (pop2),
    .dout (o_fifo2_rd_data),
    .full (full2),
    .empty(empty2)
  );

  assign o_fifo1_empty = empty1;
  assign o_fifo2_empty = empty2;
  assign o_line_done   = line_done_q;
  assign o_frame_start = frame_start_q;
  assign o_overflow    = overflow_q;
  assign o_line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_dvp_pingpong_line_buffer.sv
// Self-checking bench for dvp_pingpong_line_buffer (built with FIFO_DEPTH 4
// so that full/overflow behaviour is reachable with short lines).
module tb_dvp_pingpong_line_buffer;

  localparam int TB_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        i_pix_en;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic        i_fifo_rd_en;
  logic        i_fifo_choose;
  logic [15:0] o_fifo1_rd_data;
  logic [15:0] o_fifo2_rd_data;
  logic        o_fifo1_empty;
  logic        o_fifo2_empty;
  logic        o_line_done;
  logic        o_frame_start;
  logic        o_overflow;
  logic [11:0] o_line_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] sh1[TB_DEPTH];
  logic [15:0] sh2[TB_DEPTH];
  int          wc1 = 0;
  int          wc2 = 0;
  bit          m_parity = 1'b0;
  int          m_line_cnt = 0;

  dvp_pingpong_line_buffer #(
    .FIFO_DEPTH  (TB_DEPTH),
    .PIX_WIDTH   (16),
    .VSYNC_ACTIVE(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pix_en       (i_pix_en),
    .i_vsync        (i_vsync),
    .i_href         (i_href),
    .i_data         (i_data),
`ifdef DVP_TEST_PATTERN_EN
    .i_test_mode    (1'b0),
`endif
    .i_fifo_rd_en   (i_fifo_rd_en),
    .i_fifo_choose  (i_fifo_choose),
    .o_fifo1_rd_data(o_fifo1_rd_data),
    .o_fifo2_rd_data(o_fifo2_rd_data),
    .o_fifo1_empty  (o_fifo1_empty),
    .o_fifo2_empty  (o_fifo2_empty),
    .o_line_done    (o_line_done),
    .o_frame_start  (o_frame_start),
    .o_overflow     (o_overflow),
    .o_line_cnt     (o_line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count line-done pulses, one per cycle they are high.
  always @(negedge clk) begin
    if (rst_n && o_line_done === 1'b1) done_cnt++;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one DVP cycle, returning at the following falling edge.
  task automatic dvp_cycle(input logic en, input logic vs, input logic hr, input logic [7:0] d);
    i_pix_en = en;
    i_vsync  = vs;
    i_href   = hr;
    i_data   = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Scoreboard push: model of a depth-limited line FIFO plus its storage.
  task automatic model_push(input bit sel, input logic [15:0] w);
    if (sel) begin
      if (q2.size() < TB_DEPTH) begin
        q2.push_back(w);
        sh2[wc2 % TB_DEPTH] = w;
        wc2++;
      end
    end else begin
      if (q1.size() < TB_DEPTH) begin
        q1.push_back(w);
        sh1[wc1 % TB_DEPTH] = w;
        wc1++;
      end
    end
  endtask

  // Frame start: vsync active one cycle, then inactive.
  task automatic new_frame();
    dvp_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (o_frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL frame_start_pulse: got %b, expected 1", o_frame_start);
    end
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (o_frame_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL frame_start_width: got %b, expected 0", o_frame_start);
    end
    m_parity   = 1'b0;
    m_line_cnt = 0;
  endtask

  // One full line of n bytes start, start+step, ...
  task automatic send_line(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] b;
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = start + 8'(i) * step;
      dvp_cycle(1'b1, 1'b0, 1'b1, b);
      if (i % 2 == 1) model_push(m_parity, {prev, b});
      prev = b;
    end
    if (n % 2 == 1) model_push(m_parity, {prev, 8'h00});
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);
    m_parity = ~m_parity;
    if (m_line_cnt < 4095) m_line_cnt++;
  endtask

  // Pop every expected word from one FIFO, comparing head data, then check empty.
  task automatic drain(input bit sel);
    logic [15:0] exp;
    logic [15:0] dat;
    logic        emp;
    for (int i = 0; i < TB_DEPTH + 2; i++) begin
      if (sel && q2.size() == 0) break;
      if (!sel && q1.size() == 0) break;
      if (sel) exp = q2.pop_front();
      else     exp = q1.pop_front();
      dat = sel ? o_fifo2_rd_data : o_fifo1_rd_data;
      emp = sel ? o_fifo2_empty : o_fifo1_empty;
      n_checks++;
      if (emp !== 1'b0 || dat !== exp) begin
        n_fail++;
        $display("[TB] FAIL drain_fifo%0d: got data %h empty %b, expected data %h empty 0",
                 sel + 1, dat, emp, exp);
      end
      i_fifo_choose = sel;
      i_fifo_rd_en  = 1'b1;
      @(negedge clk);
      i_fifo_rd_en  = 1'b0;
    end
    emp = sel ? o_fifo2_empty : o_fifo1_empty;
    n_checks++;
    if (emp !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drained_empty_fifo%0d: got %b, expected 1", sel + 1, emp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_pix_en = 1'b1; i_vsync = 1'b1; i_href = 1'b0; i_data = 8'h00;
    i_fifo_rd_en = 1'b0; i_fifo_choose = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (o_fifo1_empty !== 1'b1 || o_fifo2_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_empty: got %b/%b, expected 1/1", o_fifo1_empty, o_fifo2_empty);
    end
    n_checks++;
    if (o_line_done !== 1'b0 || o_frame_start !== 1'b0 || o_overflow !== 1'b0 || o_line_cnt !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got done %b fs %b ovf %b cnt %0d, expected all 0",
               o_line_done, o_frame_start, o_overflow, o_line_cnt);
    end
    rst_n = 1'b1;
    dvp_cycle(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_single_line();
    int d0;
    d0 = done_cnt;
    new_frame();
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h01);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h02);
    model_push(1'b0, 16'h0102);
    n_checks++;
    if (o_fifo1_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL latency_0clk: got empty %b, expected 1", o_fifo1_empty);
    end
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h03);
    n_checks++;
    if (o_fifo1_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL latency_1clk: got empty %b, expected 1", o_fifo1_empty);
    end
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h04);
    model_push(1'b0, 16'h0304);
    n_checks++;
    if (o_fifo1_empty !== 1'b0 || o_fifo1_rd_data !== q1[0]) begin
      n_fail++;
      $display("[TB] FAIL latency_2clk: got empty %b data %h, expected empty 0 data %h",
               o_fifo1_empty, o_fifo1_rd_data, q1[0]);
    end
    dvp_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
    dvp_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h05);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h06);
    model_push(1'b0, 16'h0506);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h07);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h08);
    model_push(1'b0, 16'h0708);
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);
    m_parity = 1'b1;
    m_line_cnt = 1;
    n_checks++;
    if (o_line_cnt !== 12'(m_line_cnt) || done_cnt != d0 + 1) begin
      n_fail++;
      $display("[TB] FAIL single_line_count: got cnt %0d pulses %0d, expected cnt %0d pulses 1",
               o_line_cnt, done_cnt - d0, m_line_cnt);
    end
    n_checks++;
    if (o_fifo2_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_line_fifo2: got empty %b, expected 1", o_fifo2_empty);
    end
    drain(1'b0);
  endtask

  task automatic test_alternation();
    new_frame();
    send_line(8'h21, 8'h01, 4);
    send_line(8'h31, 8'h01, 4);
    n_checks++;
    if (o_line_cnt !== 12'(m_line_cnt)) begin
      n_fail++;
      $display("[TB] FAIL alt_line_cnt: got %0d, expected %0d", o_line_cnt, m_line_cnt);
    end
    drain(1'b1);
    n_checks++;
    if (o_fifo1_empty !== 1'b0 || o_fifo1_rd_data !== q1[0]) begin
      n_fail++;
      $display("[TB] FAIL alt_fifo1_untouched: got empty %b data %h, expected empty 0 data %h",
               o_fifo1_empty, o_fifo1_rd_data, q1[0]);
    end
    drain(1'b0);
  endtask

  task automatic test_odd_bytes();
    int d0;
    d0 = done_cnt;
    new_frame();
    send_line(8'hAA, 8'h11, 5);
    n_checks++;
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("[TB] FAIL odd_line_done: got %0d pulses, expected 1", done_cnt - d0);
    end
    drain(1'b0);
  endtask

  task automatic test_pop_empty();
    logic [15:0] exp;
    exp = sh1[wc1 % TB_DEPTH];
    i_fifo_choose = 1'b0;
    i_fifo_rd_en  = 1'b1;
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    i_fifo_rd_en  = 1'b0;
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (o_fifo1_empty !== 1'b1 || o_fifo1_rd_data !== exp) begin
      n_fail++;
      $display("[TB] FAIL pop_on_empty: got empty %b data %h, expected empty 1 data %h",
               o_fifo1_empty, o_fifo1_rd_data, exp);
    end
  endtask

  task automatic test_full_overflow();
    new_frame();
    send_line(8'h10, 8'h01, 12);
    n_checks++;
    if (o_overflow !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_set: got %b, expected 1", o_overflow);
    end
    n_checks++;
    if (o_fifo2_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_fifo2: got empty %b, expected 1", o_fifo2_empty);
    end
    new_frame();
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow_clear: got %b, expected 0", o_overflow);
    end
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h55);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h66);
    n_checks++;
    if (o_fifo1_rd_data !== q1[0]) begin
      n_fail++;
      $display("[TB] FAIL full_pop_head: got %h, expected %h", o_fifo1_rd_data, q1[0]);
    end
    void'(q1.pop_front());
    model_push(1'b0, 16'h5566);
    i_fifo_choose = 1'b0;
    i_fifo_rd_en  = 1'b1;
    dvp_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    i_fifo_rd_en  = 1'b0;
    idle(4);
    m_parity = 1'b1;
    m_line_cnt = 1;
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_push_pop_ovf: got %b, expected 0", o_overflow);
    end
    drain(1'b0);
  endtask

  task automatic test_vsync_abort();
    int d0;
    new_frame();
    d0 = done_cnt;
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'hAB);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'hCD);
    model_push(1'b0, 16'hABCD);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'hEF);
    dvp_cycle(1'b1, 1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 4; i++) dvp_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (done_cnt != d0 || o_line_cnt !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL vsync_abort_status: got pulses %0d cnt %0d, expected 0 and 0",
               done_cnt - d0, o_line_cnt);
    end
    drain(1'b0);
  endtask

  task automatic test_reset_midline();
    new_frame();
    send_line(8'h40, 8'h01, 4);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h50);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h51);
    model_push(m_parity, 16'h5051);
    dvp_cycle(1'b1, 1'b0, 1'b1, 8'h52);
    n_checks++;
    if (o_line_cnt !== 12'd1 || o_fifo1_empty !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_state: got cnt %0d empty1 %b, expected 1 and 0",
               o_line_cnt, o_fifo1_empty);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_fifo1_empty !== 1'b1 || o_fifo2_empty !== 1'b1 || o_line_cnt !== 12'd0 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got empty %b/%b cnt %0d ovf %b, expected 1/1 0 0",
               o_fifo1_empty, o_fifo2_empty, o_line_cnt, o_overflow);
    end
    q1.delete();
    q2.delete();
    wc1 = 0;
    wc2 = 0;
    m_parity = 1'b0;
    m_line_cnt = 0;
    i_vsync = 1'b1;
    i_href  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) dvp_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (o_fifo1_empty !== 1'b1 || o_fifo2_empty !== 1'b1 || o_line_cnt !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL post_reset: got empty %b/%b cnt %0d, expected 1/1 0",
               o_fifo1_empty, o_fifo2_empty, o_line_cnt);
    end
  endtask

  initial begin
    $display("[TB] starting dvp_pingpong_line_buffer bench");
    test_reset();
    test_single_line();
    test_alternation();
    test_pop_empty();
    test_odd_bytes();
    test_full_overflow();
    test_vsync_abort();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
